// File: rtl/addsub_seq_arb_if.sv
// Handshake bundle for the shared serial add/subtract unit.
// Two requester channels in, one response channel out.
interface addsub_seq_arb_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_sub;

   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_sub;

   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_r;
   logic         rsp_cb;
   logic         rsp_ovf;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sub,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_r, rsp_cb, rsp_ovf,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sub,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_r, rsp_cb, rsp_ovf,
      input  rsp_ready
   );
endinterface

// File: rtl/addsub_seq_arb.sv
// Two-requester round-robin front end for a 4-bit serial add/subtract.
// One nibble per cycle, LSB first, carry chained between nibbles.
module addsub_seq_arb #(
   parameter int NIBBLES = 4
) (
   input logic             clk,
   input logic             rst,
   addsub_seq_arb_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic         ptr_q, ptr_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic         sub_q, sub_d;
   logic         id_q, id_d;
   logic         carry_q, carry_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0] r_q, r_d;
   logic         cb_q, cb_d;
   logic         ovf_q, ovf_d;

   logic         gnt0;
   logic         gnt1;
   logic [3:0]   a_nib;
   logic [3:0]   b_nib;
   logic [4:0]   sum5;
   logic         c3;

   // Grant: single valid wins, a tie goes to the pointer.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == S_IDLE) begin
         gnt0 = bus.req0_valid & (~bus.req1_valid | ~ptr_q);
         gnt1 = bus.req1_valid & (~bus.req0_valid |  ptr_q);
      end
   end

   assign bus.req0_ready = gnt0;
   assign bus.req1_ready = gnt1;

   // Nibble slice: B inverted for subtract, carry-in from the chain.
   always_comb begin
      a_nib = a_q[{idx_q, 2'b00} +: 4];
      b_nib = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
      sum5  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
      c3    = a_nib[3] ^ b_nib[3] ^ sum5[3];
   end

   // Sequencer: accept, step through nibbles, hold result until taken.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      id_d    = id_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      r_d     = r_q;
      cb_d    = cb_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (gnt0 | gnt1) begin
               a_d     = gnt1 ? bus.req1_a   : bus.req0_a;
               b_d     = gnt1 ? bus.req1_b   : bus.req0_b;
               sub_d   = gnt1 ? bus.req1_sub : bus.req0_sub;
               carry_d = gnt1 ? bus.req1_sub : bus.req0_sub;
               id_d    = gnt1;
               ptr_d   = ~gnt1;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            r_d[{idx_q, 2'b00} +: 4] = sum5[3:0];
            carry_d = sum5[4];
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST) begin
               cb_d    = sum5[4];
               ovf_d   = c3 ^ sum5[4];
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         id_q    <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         r_q     <= '0;
         cb_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         id_q    <= id_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         r_q     <= r_d;
         cb_q    <= cb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.rsp_valid = (state_q == S_DONE);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_r     = r_q;
   assign bus.rsp_cb    = cb_q;
   assign bus.rsp_ovf   = ovf_q;
endmodule

// File: tb/tb_addsub_seq_arb.sv
// Bench for addsub_seq_arb: transaction-level model plus directed vectors.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_addsub_seq_arb;
   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   addsub_seq_arb_if #(.NIBBLES(NIB)) bus ();

   addsub_seq_arb #(.NIBBLES(NIB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic from first principles.
   function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit s, output logic [W-1:0] r,
                                output bit cb, output bit ovf);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint sr;
      longint lim = longint'(1) << (W - 1);
      if (!s) begin
         r  = W'(ua + ub);
         cb = (ua + ub) >= (longint'(1) << W);
         sr = sa + sb;
      end else begin
         r  = W'(ua - ub);
         cb = ua >= ub;
         sr = sa - sb;
      end
      ovf = (sr >= lim) || (sr < -lim);
   endfunction

   bit           m_on   = 1'b0;
   bit           m_busy = 1'b0;
   bit           m_ptr  = 1'b0;
   bit           m_rstd = 1'b0;
   int           m_cnt  = 0;
   logic [W-1:0] m_r    = '0;
   bit           m_cb   = 1'b0;
   bit           m_ovf  = 1'b0;
   bit           m_id   = 1'b0;
   int           rsp_log[$];

   // Per-cycle compare against the model, then advance the model.
   always @(negedge clk) begin
      bit e0;
      bit e1;
      bit ev;
      bit v0;
      bit v1;
      e0 = 1'b0;
      e1 = 1'b0;
      ev = 1'b0;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      if (m_on) begin
         ev = m_busy && (m_cnt >= NIB);
         if (!m_busy) begin
            if (v0 && v1) begin
               e0 = !m_ptr;
               e1 = m_ptr;
            end else begin
               e0 = v0;
               e1 = v1;
            end
         end
         chk("req0_ready", 64'(bus.req0_ready), 64'(e0));
         chk("req1_ready", 64'(bus.req1_ready), 64'(e1));
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
         if (ev) begin
            chk("rsp_r", 64'(bus.rsp_r), 64'(m_r));
            chk("rsp_cb", 64'(bus.rsp_cb), 64'(m_cb));
            chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(m_ovf));
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
         end
         if (m_rstd) begin
            chk("rst_r", 64'(bus.rsp_r), 64'd0);
            chk("rst_cb", 64'(bus.rsp_cb), 64'd0);
            chk("rst_ovf", 64'(bus.rsp_ovf), 64'd0);
            chk("rst_id", 64'(bus.rsp_id), 64'd0);
         end
      end
      if (rst) begin
         m_on   = 1'b1;
         m_busy = 1'b0;
         m_ptr  = 1'b0;
         m_cnt  = 0;
         m_rstd = 1'b1;
      end else if (m_on) begin
         m_rstd = 1'b0;
         if (m_busy) begin
            if (ev && bus.rsp_ready) begin
               m_busy = 1'b0;
               rsp_log.push_back(int'(bus.rsp_id));
            end else begin
               m_cnt++;
            end
         end else if (e0 || e1) begin
            if (e1) calc(bus.req1_a, bus.req1_b, bus.req1_sub, m_r, m_cb, m_ovf);
            else    calc(bus.req0_a, bus.req0_b, bus.req0_sub, m_r, m_cb, m_ovf);
            m_id   = e1;
            m_ptr  = !e1;
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end
   end

   task automatic set_req(input bit id, input bit v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit s);
      if (id) begin
         bus.req1_valid = v;
         bus.req1_a     = a;
         bus.req1_b     = b;
         bus.req1_sub   = s;
      end else begin
         bus.req0_valid = v;
         bus.req0_a     = a;
         bus.req0_b     = b;
         bus.req0_sub   = s;
      end
   endtask

   // Present one op, wait for its accept, then scramble the inputs.
   task automatic issue(input bit id, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit s);
      bit ok = 1'b0;
      set_req(id, 1'b1, a, b, s);
      repeat (20) begin
         if (!ok) begin
            @(negedge clk);
            ok = id ? bus.req1_ready : bus.req0_ready;
         end
      end
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      set_req(id, 1'b0, ~a, ~b, ~s);
   endtask

   task automatic wait_rsp(output int lat);
      bit got = 1'b0;
      lat = 0;
      repeat (40) begin
         if (!got) begin
            @(negedge clk);
            lat++;
            got = bus.rsp_valid;
         end
      end
      if (!got) chk("rsp_timeout", 64'd0, 64'd1);
   endtask

   task automatic op_check(input string nm, input bit id,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit s, input logic [W-1:0] er,
                           input bit ecb, input bit eovf);
      int lat;
      issue(id, a, b, s);
      wait_rsp(lat);
      chk({nm, "_lat"}, 64'(lat - 1), 64'd4);
      chk({nm, "_r"}, 64'(bus.rsp_r), 64'(er));
      chk({nm, "_cb"}, 64'(bus.rsp_cb), 64'(ecb));
      chk({nm, "_ovf"}, 64'(bus.rsp_ovf), 64'(eovf));
      chk({nm, "_id"}, 64'(bus.rsp_id), 64'(id));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0);
      bus.rsp_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reset_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset_r", 64'(bus.rsp_r), 64'd0);
      chk("reset_id", 64'(bus.rsp_id), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      op_check("add0", 1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
      op_check("sub1", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op_check("wrap", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      op_check("ovfa", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op_check("ovfs", 1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Backpressure: result must hold for 5 stalled cycles.
      bus.rsp_ready = 1'b0;
      issue(1'b0, 16'hA5A5, 16'h5A5A, 1'b1);
      wait_rsp(lat);
      repeat (5) @(negedge clk);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_r", 64'(bus.rsp_r), 64'h4B4B);
      chk("bp_cb", 64'(bus.rsp_cb), 64'd1);
      chk("bp_ovf", 64'(bus.rsp_ovf), 64'd1);
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_last", 64'(bus.rsp_valid), 64'd1);
      @(negedge clk);
      chk("bp_done", 64'(bus.rsp_valid), 64'd0);

      // Arbitration after reset: both requesters always valid.
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rsp_log.delete();
      set_req(1'b0, 1'b1, 16'h0001, 16'h0002, 1'b0);
      set_req(1'b1, 1'b1, 16'h0010, 16'h0001, 1'b1);
      repeat (80) begin
         if (rsp_log.size() < 4) @(posedge clk);
      end
      #1;
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      set_req(1'b1, 1'b0, '0, '0, 1'b0);
      chk("arb_count", 64'(rsp_log.size()), 64'd4);
      if (rsp_log.size() >= 4) begin
         chk("arb_g0", 64'(rsp_log[0]), 64'd0);
         chk("arb_g1", 64'(rsp_log[1]), 64'd1);
         chk("arb_g2", 64'(rsp_log[2]), 64'd0);
         chk("arb_g3", 64'(rsp_log[3]), 64'd1);
      end
      repeat (2) @(posedge clk);
      #1;

      // Reset after nibble 1 aborts the op; req0 then wins a tie.
      issue(1'b0, 16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_valid", 64'(bus.rsp_valid), 64'd0);
      chk("abort_r", 64'(bus.rsp_r), 64'd0);
      @(posedge clk);
      #1;
      set_req(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
      set_req(1'b1, 1'b1, 16'h0003, 16'h0004, 1'b0);
      @(negedge clk);
      chk("tie_r0", 64'(bus.req0_ready), 64'd1);
      chk("tie_r1", 64'(bus.req1_ready), 64'd0);
      @(posedge clk);
      #1;
      set_req(1'b0, 1'b0, '0, '0, 1'b0);
      wait_rsp(lat);
      chk("fresh_lat", 64'(lat - 1), 64'd4);
      chk("fresh_r", 64'(bus.rsp_r), 64'h0100);
      chk("fresh_cb", 64'(bus.rsp_cb), 64'd0);
      chk("fresh_ovf", 64'(bus.rsp_ovf), 64'd0);
      chk("fresh_id", 64'(bus.rsp_id), 64'd0);
      @(posedge clk);
      #1;
      issue(1'b1, 16'h0003, 16'h0004, 1'b0);
      wait_rsp(lat);
      chk("next_r", 64'(bus.rsp_r), 64'h0007);
      chk("next_id", 64'(bus.rsp_id), 64'd1);
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/addsub_seq_arb.md
Name: addsub_seq_arb

Overview:
- Shares one 4-bit add/subtract nibble datapath between two requesters.
- Performs W-bit (W = 4*NIBBLES) add or subtract serially, one nibble per cycle, LSB first, chaining the carry/borrow.
- Round-robin arbitration on the request side; valid/ready handshake on both sides.
- Sits between the nibble adder/subtractor and wider arithmetic clients that cannot afford a full-width adder.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; W = 4*NIBBLES (default 16)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid
req0_a  input  W  operand A
req0_b  input  W  operand B
req0_sub  input  1  1 = A-B, 0 = A+B
req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result when high with rsp_valid
rsp_id  output  1  requester that issued the result (0/1)
rsp_r  output  W  result, modulo 2^W
rsp_cb  output  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned)
rsp_ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
- Values after any rst cycle: state IDLE, rsp_valid=0, rsp_id=0, rsp_r=0, rsp_cb=0, rsp_ovf=0, round-robin pointer=0.
- Reset mid-operation: rst in RUN or DONE aborts the operation and discards partial results; no response is produced.
- States: IDLE, RUN, DONE.
- IDLE, requesting/ready: reqN_ready is combinational.
  - Only one requester is readied per cycle.
  - If only one requester is valid, that one gets ready=1.
  - If both are valid, the one named by the pointer gets ready=1.
  - With no valid requester, both readies are 0.
- IDLE, accept: on a handshake edge the block captures a, b, sub and id, then loads carry := sub and nibble index := 0.
  - The pointer moves to the other requester (1 - granted id).
  - State goes to RUN.
- RUN, per cycle (nibble k):
  - r[4k+3:4k] = a_k + (b_k XOR {4{sub}}) + carry; carry := nibble carry-out.
  - On the last nibble (k = NIBBLES-1), rsp_cb := carry-out and rsp_ovf := carry-into-bit3 XOR carry-out.
  - State then goes to DONE.
  - Both readies are 0 throughout RUN.
- Latency: rsp_valid is first high exactly NIBBLES cycles after the accept edge (4 cycles at default).
- DONE: rsp_valid=1. rsp_r, rsp_cb, rsp_ovf and rsp_id stay stable until rsp_ready=1.
  - On the handshake edge, rsp_valid returns to 0 and state goes to IDLE.
  - Readies stay 0 in DONE, including the handshake cycle; the next accept is possible at the earliest one cycle later.
- Operands, sub and id are held internally; requester inputs may change after accept with no effect.
- Arithmetic is unsigned modulo 2^W. rsp_ovf is valid for signed interpretation. Both are independent of requester id.
- reqN_ready must not depend on rsp_ready.

Test Plan:
- Req0: 0x1234 + 0x0FCD, sub=0 -> rsp_valid 4 cycles after accept; rsp_r=0x2201, rsp_cb=0, rsp_ovf=0, rsp_id=0.
- Req1: 0x0005 - 0x0007 -> rsp_r=0xFFFE, rsp_cb=0, rsp_ovf=0, rsp_id=1. Then 0xFFFF + 0x0001 -> rsp_r=0x0000, rsp_cb=1, rsp_ovf=0.
- Overflow: 0x7FFF + 0x0001 -> rsp_r=0x8000, cb=0, ovf=1. Then 0x8000 - 0x0001 -> rsp_r=0x7FFF, cb=1, ovf=1.
- Arbitration: after reset, both valid continuously, rsp_ready=1 -> grants/rsp_id sequence 0,1,0,1. Never both readies high in one cycle; readies 0 in RUN/DONE.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and all rsp_* outputs stable; both readies 0; completes on the rsp_ready edge.
- Reset mid-RUN: assert rst after nibble 1 -> next cycle all outputs at reset values and pointer=0 (req0 wins a tie). A fresh 0x00FF + 0x0001 then returns rsp_r=0x0100, cb=0, ovf=0.
